// File: rtl/div32_seq.sv
// div32_seq: sequential radix-2 restoring 32-bit divider, y = {remainder, quotient}
// Ports: clk, rst (sync, active-high); start/is_signed/a/b request inputs;
//        busy, done (1-cycle pulse), dbz (divide-by-zero), y {rem, quo} registered outputs.
module div32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [63:0] y
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] d, rem, quo;
  logic        qneg, rneg, dz;
  logic [32:0] diff;
  // quo doubles as the dividend shift register: dividend bits leave at the MSB, quotient bits enter at the LSB
  assign diff = {rem, quo[31]} - {1'b0, d};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      d     <= '0;
      rem   <= '0;
      quo   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      y     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            quo   <= (is_signed && a[31]) ? -a : a;
            d     <= (is_signed && b[31]) ? -b : b;
            rem   <= '0;
            qneg  <= is_signed & (a[31] ^ b[31]);
            rneg  <= is_signed & a[31];
            dz    <= (b == '0);
            cnt   <= 5'd31;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
          quo <= {quo[30:0], ~diff[32]};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        default: begin
          // with b == 0 the remainder ends as |a|, which the dividend-sign fix turns back into a
          y     <= {rneg ? -rem : rem, dz ? 32'hFFFF_FFFF : (qneg ? -quo : quo)};
          dbz   <= dz;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed-vector and randomized self-checking bench for div32_seq
module tb_div32_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, dbz;
  logic [63:0] y;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] prev_y = '0;
  logic        prev_dbz = 1'b0;

  div32_seq dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .dbz(dbz), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] y;
    bit          dbz;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] x, input logic [31:0] z);
    longint sx, sz, q, r;
    if (z == '0) return {x, 32'hFFFF_FFFF};
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sz = s ? longint'($signed(z)) : longint'({32'b0, z});
    q = sx / sz;
    r = sx % sz;
    return {r[31:0], q[31:0]};
  endfunction

  // caller is at a negedge; this negedge is cycle 0
  task automatic go(input bit s, input logic [31:0] x, input logic [31:0] z);
    start = 1'b1;
    is_signed = s;
    a = x;
    b = z;
  endtask

  // returns at the negedge of the done cycle, so a chained go() lands in the DONE cycle
  task automatic await_done(input logic [63:0] ey, input bit edbz, input string nm,
                            input int poke, input int kill);
    int bad_busy = 0;
    int bad_hold = 0;
    int pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == poke);
      if (n == poke) begin
        is_signed = ~is_signed;
        a = 32'd5;
        b = 32'd1;
      end
      if (n < 34) begin
        if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
        if (y !== prev_y || dbz !== prev_dbz) bad_hold++;
      end
      if (n == kill) begin
        rst = 1'b1;
        @(negedge clk);
        chk({nm, "_rst_busy"}, {63'b0, busy}, 64'd0);
        chk({nm, "_rst_done"}, {63'b0, done}, 64'd0);
        chk({nm, "_rst_dbz"}, {63'b0, dbz}, 64'd0);
        chk({nm, "_rst_y"}, y, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (done) pulses++;
        end
        chk({nm, "_no_done"}, 64'(pulses), 64'd0);
        chk({nm, "_busy_before_rst"}, 64'(bad_busy), 64'd0);
        prev_y = '0;
        prev_dbz = 1'b0;
        return;
      end
      if (n == 34) begin
        chk({nm, "_done"}, {63'b0, done}, 64'd1);
        chk({nm, "_busy_end"}, {63'b0, busy}, 64'd0);
        chk({nm, "_busy_hold"}, 64'(bad_busy + bad_hold), 64'd0);
        chk({nm, "_y"}, y, ey);
        chk({nm, "_dbz"}, {63'b0, dbz}, {63'b0, edbz});
        prev_y = ey;
        prev_dbz = edbz;
        return;
      end
    end
  endtask

  initial begin
    tv[0]  = '{0, 32'd100, 32'd7, {32'd2, 32'd14}, 0};
    tv[1]  = '{1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0};
    tv[2]  = '{1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0};
    tv[3]  = '{0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 0};
    tv[4]  = '{0, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, 1};
    tv[5]  = '{1, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, 1};
    tv[6]  = '{0, 32'd10, 32'd3, {32'd1, 32'd3}, 0};
    tv[7]  = '{0, 32'd7, 32'd100, {32'd7, 32'd0}, 0};
    tv[8]  = '{1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0};
    tv[9]  = '{1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0};
    tv[10] = '{1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 0};
    tv[11] = '{0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 0};
    tv[12] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1}, 0};
    tv[13] = '{1, 32'hFFFF_FFFB, 32'h0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_dbz", {63'b0, dbz}, 64'd0);
    chk("reset_y", y, 64'd0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      go(tv[i].sgn, tv[i].a, tv[i].b);
      await_done(tv[i].y, tv[i].dbz, $sformatf("vec%0d", i), 0, 0);
    end
    @(negedge clk);
    go(0, 32'd100, 32'd7);
    await_done({32'd2, 32'd14}, 0, "ignore_start", 10, 0);
    go(0, 32'd15, 32'd4);
    await_done({32'd3, 32'd3}, 0, "back_to_back", 0, 0);
    @(negedge clk);
    go(0, 32'd100, 32'd7);
    await_done('0, 0, "abort", 0, 20);
    @(negedge clk);
    go(0, 32'd10, 32'd3);
    await_done({32'd1, 32'd3}, 0, "after_abort", 0, 0);
    for (int i = 0; i < 1000; i++) begin
      bit s;
      logic [31:0] x, z;
      s = 1'($urandom);
      x = $urandom;
      case ($urandom % 4)
        0: z = $urandom;
        1: z = $urandom % 16;
        2: z = {28'($urandom % 2 ? 28'hFFFFFFF : 28'h0), 4'($urandom)};
        default: z = $urandom >> ($urandom % 32);
      endcase
      if ($urandom % 8 == 0) x = x >> ($urandom % 32);
      @(negedge clk);
      go(s, x, z);
      await_done(model(s, x, z), z == '0, "rand", 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
